// File: rtl/sobel_window_gen.sv
// sobel_window_gen: turns a raster pixel stream into 3x3 windows
// for a downstream Sobel detector, one window per non-border pixel.
module sobel_window_gen #(
    parameter int IMG_COLS = 576,
    parameter int IMG_ROWS = 436
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] pix_in,
    input  logic       pix_valid,
    input  logic       sof,
    output logic [7:0] z1,
    output logic [7:0] z2,
    output logic [7:0] z3,
    output logic [7:0] z4,
    output logic [7:0] z5,
    output logic [7:0] z6,
    output logic [7:0] z7,
    output logic [7:0] z8,
    output logic [7:0] z9,
    output logic       win_valid,
    output logic       frame_done
);

    localparam int CW = $clog2(IMG_COLS);
    localparam int RW = $clog2(IMG_ROWS);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_COLS - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_ROWS - 1);

    typedef enum logic {FILL, STREAM} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] col;
    logic [CW-1:0] col_eff;
    logic [CW-1:0] col_nxt;
    logic [RW-1:0] row;
    logic [RW-1:0] row_eff;
    logic [RW-1:0] row_nxt;
    logic          last_col;
    logic          last_row;
    logic          emit;

    logic [7:0] line1 [IMG_COLS];
    logic [7:0] line2 [IMG_COLS];
    logic [7:0] top;
    logic [7:0] mid;
    logic [7:0] top1, top2;
    logic [7:0] mid1, mid2;
    logic [7:0] bot1, bot2;

    // sof on an accepted pixel restarts the frame at (0,0)
    always_comb begin
        col_eff   = sof ? '0 : col;
        row_eff   = sof ? '0 : row;
        top       = line2[col_eff];
        mid       = line1[col_eff];
        last_col  = (col_eff == COL_LAST);
        last_row  = (row_eff == ROW_LAST);
        col_nxt   = last_col ? '0 : col_eff + CW'(1);
        row_nxt   = row_eff;
        if (last_col) begin
            row_nxt = last_row ? '0 : row_eff + RW'(1);
        end
        emit      = pix_valid && !sof && (state == STREAM)
                    && (col_eff >= CW'(2));
        state_nxt = state;
        if (pix_valid) begin
            unique case (state)
                FILL: begin
                    if (last_col && row_eff == RW'(1)) begin
                        state_nxt = STREAM;
                    end
                end
                STREAM: begin
                    if (sof || (last_col && last_row)) begin
                        state_nxt = FILL;
                    end
                end
                default: state_nxt = FILL;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= FILL;
            col        <= '0;
            row        <= '0;
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            z1 <= '0; z2 <= '0; z3 <= '0;
            z4 <= '0; z5 <= '0; z6 <= '0;
            z7 <= '0; z8 <= '0; z9 <= '0;
        end else begin
            state      <= state_nxt;
            win_valid  <= emit;
            frame_done <= emit && last_col && last_row;
            if (pix_valid) begin
                col <= col_nxt;
                row <= row_nxt;
            end
            if (emit) begin
                z1 <= top2; z2 <= top1; z3 <= top;
                z4 <= mid2; z5 <= mid1; z6 <= mid;
                z7 <= bot2; z8 <= bot1; z9 <= pix_in;
            end
        end
    end

    // Line buffers and column taps hold only pixel data; never reset
    always_ff @(posedge clk) begin
        if (pix_valid) begin
            line1[col_eff] <= pix_in;
            line2[col_eff] <= mid;
            top2 <= top1;
            top1 <= top;
            mid2 <= mid1;
            mid1 <= mid;
            bot2 <= bot1;
            bot1 <= pix_in;
        end
    end

endmodule

// File: doc/sobel_window_gen.md
SOBEL_WINDOW_GEN -- requirements
Module: sobel_window_gen

Interface
REQ-001 SHALL have parameter IMG_COLS, default 576, pixels per image row (min 3).
REQ-002 SHALL have parameter IMG_ROWS, default 436, rows per image (min 3).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port pix_in  input  8  raster-order source pixel.
REQ-006 SHALL have port pix_valid  input  1  pix_in is accepted on this cycle.
REQ-007 SHALL have port sof  input  1  start of frame, qualified by pix_valid.
REQ-008 SHALL have ports z1..z9  output  8 each  3x3 window, row-major, to sobel3x3det.
REQ-009 SHALL have port win_valid  output  1  z1..z9 hold a new window this cycle.
REQ-010 SHALL have port frame_done  output  1  single-cycle pulse, last window of frame.

Function
REQ-011 SHALL accept one pixel per cycle when pix_valid=1; no backpressure; pix_valid=0 cycles SHALL leave all state unchanged.
REQ-012 SHALL track input position with col counter (0..IMG_COLS-1) and row counter (0..IMG_ROWS-1); col wraps to 0 and row increments after col=IMG_COLS-1.
REQ-013 SHALL wrap row to 0 after the pixel at (IMG_ROWS-1, IMG_COLS-1), ready for the next frame without reset.
REQ-014 SHALL treat an accepted pixel with sof=1 as position (0,0), overriding counters; sof with pix_valid=0 SHALL be ignored.
REQ-015 SHALL store the two previous rows in two line buffers of IMG_COLS x 8 bits, plus a 3-column shift register per window row.
REQ-016 SHALL run a state machine FILL -> STREAM: FILL while row<2; STREAM for rows 2..IMG_ROWS-1; return to FILL on wrap or on sof.
REQ-017 SHALL, on accepting pixel at (r,c) with r>=2 and c>=2, produce on the next cycle win_valid=1 and z1..z9 = src[r-2][c-2], src[r-2][c-1], src[r-2][c], src[r-1][c-2], src[r-1][c-1], src[r-1][c], src[r][c-2], src[r][c-1], src[r][c].
REQ-018 SHALL therefore emit exactly (IMG_ROWS-2)*(IMG_COLS-2) windows per frame, centred on every non-border pixel, in raster order.
REQ-019 SHALL register z1..z9 and win_valid (latency exactly 1 cycle from acceptance); z1..z9 SHALL hold their last value while win_valid=0.
REQ-020 SHALL never form a window across a row boundary: columns 0 and 1 of each row produce no window.
REQ-021 SHALL assert frame_done in the same cycle as win_valid for the window of pixel (IMG_ROWS-1, IMG_COLS-1), and at no other time.
REQ-022 SHALL, if sof arrives mid-frame, drop the partial frame: no further windows until row 2 col 2 of the new frame; frame_done not asserted for the dropped frame.
REQ-023 SHALL not require line-buffer contents to be initialised; stale data SHALL never appear in a valid window.

Reset
REQ-024 SHALL, while reset=0, immediately force row=0, col=0, state=FILL, win_valid=0, frame_done=0, z1..z9=8'h00.
REQ-025 SHALL, after reset release mid-frame, treat the next accepted pixel as (0,0) regardless of sof.
REQ-026 SHALL not clear line buffers on reset.

Verification
REQ-027 SHALL verify IMG_COLS=4, IMG_ROWS=3, pixels 0x00..0x0B streamed back-to-back -> two windows: 00 01 02 04 05 06 08 09 0A the cycle after pixel 0x0A, then 01 02 03 05 06 07 09 0A 0B with frame_done=1 the cycle after 0x0B.
REQ-028 SHALL verify the same frame with pix_valid deasserted every other cycle -> identical window values, each 1 cycle after its completing pixel, no extra win_valid.
REQ-029 SHALL verify two frames back-to-back (second pixels 0x10..0x1B, sof on first) -> second frame windows 10 11 12 14 15 16 18 19 1A and 11 12 13 15 16 17 19 1A 1B, one frame_done per frame.
REQ-030 SHALL verify sof asserted at pixel 6 of a frame -> no window and no frame_done until a full new 3-row fill; then correct windows.
REQ-031 SHALL verify reset=0 asserted asynchronously mid-STREAM -> outputs zero without a clock edge; following clean frame gives exactly (R-2)*(C-2) correct windows.
REQ-032 SHALL verify default parameters 576x436 with random pixels against a software model -> 574*434 windows matching, one frame_done.
